// File: rtl/ram_loader_pkg.sv
// Shared types and default widths for the ram_loader block.
package ram_loader_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } ram_loader_state_t;

endpackage

// File: rtl/xor_accum.sv
// Running XOR checksum register with synchronous clear and enable.
module xor_accum
    import ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum ^ i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/ram_loader.sv
// Streams words into sequential RAM addresses 0..N-1 and pulses done.
// Define RAM_LOADER_VERIFY_EN to add a checksum read-back pass after the load.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting words, one RAM write per handshake
// VERIFY | reading RAM back and comparing checksums
// DONE   | one-cycle completion pulse
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_verify_err
);

`ifdef RAM_LOADER_VERIFY_EN
    localparam ram_loader_state_t LOAD_EXIT = VERIFY;
`else
    localparam ram_loader_state_t LOAD_EXIT = DONE;
`endif

    ram_loader_state_t     r_state;
    ram_loader_state_t     w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_in_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_hs;
    logic                  w_start_load;
    logic                  w_last_hs;
    logic                  w_vlast;
    logic [DATA_WIDTH-1:0] w_load_sum;

    assign w_hs         = i_in_valid & w_in_ready;
    assign w_start_load = (r_state == IDLE) & i_start;
    assign w_last_hs    = w_hs & (&r_ptr);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = LOAD;
            LOAD:    if (w_last_hs) w_next_state = LOAD_EXIT;
            VERIFY:  if (w_vlast) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            IDLE:    w_busy = 1'b0;
            LOAD:    w_in_ready = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // The pointer wraps to 0 after the last word; LOAD exits on that same handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_hs;
            if (w_hs) begin
                r_waddr <= r_ptr;
                r_wdata <= i_in_data;
                r_ptr   <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_start_load) begin
                r_ptr <= '0;
            end
        end
    end

    xor_accum #(.DATA_WIDTH(DATA_WIDTH)) u_load_sum (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_start_load),
        .i_en    (w_hs),
        .i_data  (i_in_data),
        .o_sum   (w_load_sum)
    );

`ifdef RAM_LOADER_VERIFY_EN
    logic [ADDR_WIDTH:0]   r_vcnt;
    logic                  r_verify_err;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_sum;

    // r_vcnt counts 0..N; rdata in the cycle with r_vcnt=k belongs to address k-1.
    assign w_rd_en = (r_state == VERIFY) && (r_vcnt != '0);
    assign w_vlast = (r_state == VERIFY) && r_vcnt[ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vcnt       <= '0;
            r_verify_err <= 1'b0;
        end else begin
            if (r_state == VERIFY) begin
                r_vcnt <= r_vcnt + (ADDR_WIDTH + 1)'(1);
            end else begin
                r_vcnt <= '0;
            end
            if (w_start_load) begin
                r_verify_err <= 1'b0;
            end else if (w_vlast && ((w_rd_sum ^ i_rdata) != w_load_sum)) begin
                r_verify_err <= 1'b1;
            end
        end
    end

    xor_accum #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_start_load),
        .i_en    (w_rd_en),
        .i_data  (i_rdata),
        .o_sum   (w_rd_sum)
    );

    assign o_raddr      = r_vcnt[ADDR_WIDTH-1:0];
    assign o_verify_err = r_verify_err;
`else
    logic w_unused_verify;

    assign w_vlast         = 1'b0;
    assign w_unused_verify = ^{i_rdata, w_load_sum};
    assign o_raddr         = '0;
    assign o_verify_err    = 1'b0;
`endif

    assign o_in_ready = w_in_ready;
    assign o_busy     = w_busy;
    assign o_done     = w_done;
    assign o_we       = r_we;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;

endmodule
